regfile_sched: RTL and testbench

Write-port scheduler for the banked ARM register file. It shares the file's single write port (`Write_Reg`/`W_Addr`/`W_Data`) and PC write port (`Write_PC`/`PC_New`) between two requesters: core writeback (port 0) and the debug/board loader (port 1). It drives the mode bus `M`, generates sequential PC steps, and supports a debug lock for atomic multi-write bursts. It sits directly in front of `regFile`; its outputs connect 1:1 to `regFile` inputs of the same name.

---
 rtl/regfile_sched_pkg.sv | 29 ++
 rtl/regfile_sched_starve.sv | 54 +++++
 rtl/regfile_sched.sv | 141 ++++++++++++++
 tb/tb_regfile_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sched_pkg.sv
// Shared definitions for the register-file write-port scheduler:
// ARM mode encodings, the mode legality check and the lock-state encoding.
package regfile_sched_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // True for the seven CPSR modes that select a real register bank.
  function automatic logic mode_legal(input logic [4:0] mode);
    logic ok;
    case (mode)
      MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
      MODE_ABT, MODE_UND, MODE_SYS: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/regfile_sched_starve.sv
// Two-requester arbiter: core has priority, debug is forced through once it
// has waited STARVE_MAX cycles. While locked, debug owns the port and the
// starvation counter holds its value.
module starve_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic Rst,
  input  logic wb_valid,
  input  logic dbg_valid,
  input  logic locked,
  output logic wb_gnt,
  output logic dbg_gnt
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starved;

  assign starved = (starve_cnt_q == CNT_MAX);

  // Grant selection: lock gives debug exclusive ownership, otherwise core
  // wins unless debug has been starved long enough.
  always_comb begin
    wb_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (locked) begin
      dbg_gnt = dbg_valid;
    end else begin
      dbg_gnt = dbg_valid & (~wb_valid | starved);
      wb_gnt  = wb_valid & ~(dbg_valid & starved);
    end
  end

  // Starvation count: grows while debug waits, saturates, clears on grant.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!locked) begin
      if (dbg_gnt)
        starve_cnt_d = '0;
      else if (dbg_valid && !starved)
        starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (Rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/regfile_sched.sv
// Shares the register file's write and PC ports between core writeback and
// the debug loader; one issue stage, so a write strobes the cycle after accept.
// Requests are accepted back to back; a debug lock holds off the core.
module regfile_sched
  import regfile_sched_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int PC_STEP    = 4
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [4:0]  core_mode,
  input  logic        wb_valid,
  input  logic        wb_pc,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [4:0]  wb_mode,
  output logic        wb_ready,
  input  logic        dbg_valid,
  input  logic        dbg_pc,
  input  logic        dbg_lock,
  input  logic [3:0]  dbg_addr,
  input  logic [31:0] dbg_data,
  input  logic [4:0]  dbg_mode,
  output logic        dbg_ready,
  input  logic        pc_inc,
  input  logic [31:0] R_Data_PC,
  output logic [4:0]  M,
  output logic [3:0]  W_Addr,
  output logic [31:0] W_Data,
  output logic        Write_Reg,
  output logic        Write_PC,
  output logic [31:0] PC_New,
  output logic        mode_err,
  output logic [15:0] wr_count
);

  localparam logic [31:0] PC_STEP_W = 32'(PC_STEP);

  state_e state_q, state_d;
  logic   locked, wb_gnt, dbg_gnt;

  logic        iss_v_q, iss_v_d;
  logic        iss_pc_q, iss_pc_d;
  logic [3:0]  iss_addr_q, iss_addr_d;
  logic [31:0] iss_data_q, iss_data_d;
  logic [4:0]  iss_mode_q, iss_mode_d;
  logic        inc_q;
  logic [15:0] wr_count_q;
  logic        mode_ok, pc_wr_exp;

  starve_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk      (clk),
    .Rst      (Rst),
    .wb_valid (wb_valid),
    .dbg_valid(dbg_valid),
    .locked   (locked),
    .wb_gnt   (wb_gnt),
    .dbg_gnt  (dbg_gnt)
  );

  // Lock state register.
  always_ff @(posedge clk) begin
    if (Rst) state_q <= ST_OPEN;
    else     state_q <= state_d;
  end

  // Lock transitions are driven only by accepted debug beats.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OPEN:   if (dbg_gnt && dbg_lock)  state_d = ST_LOCKED;
      ST_LOCKED: if (dbg_gnt && !dbg_lock) state_d = ST_OPEN;
      default:   state_d = ST_OPEN;
    endcase
  end

  // Handshake outputs follow the arbiter grants.
  always_comb begin
    locked    = (state_q == ST_LOCKED);
    wb_ready  = wb_gnt;
    dbg_ready = dbg_gnt;
  end

  // Load the issue stage from whichever requester was granted.
  always_comb begin
    iss_v_d    = wb_gnt | dbg_gnt;
    iss_pc_d   = iss_pc_q;
    iss_addr_d = iss_addr_q;
    iss_data_d = iss_data_q;
    iss_mode_d = iss_mode_q;
    if (dbg_gnt) begin
      iss_pc_d   = dbg_pc;
      iss_addr_d = dbg_addr;
      iss_data_d = dbg_data;
      iss_mode_d = dbg_mode;
    end else if (wb_gnt) begin
      iss_pc_d   = wb_pc;
      iss_addr_d = wb_addr;
      iss_data_d = wb_data;
      iss_mode_d = wb_mode;
    end
  end

  // Issue registers, PC-step request and write counter.
  always_ff @(posedge clk) begin
    if (Rst) begin
      iss_v_q    <= 1'b0;
      iss_pc_q   <= 1'b0;
      iss_addr_q <= '0;
      iss_data_q <= '0;
      iss_mode_q <= '0;
      inc_q      <= 1'b0;
      wr_count_q <= '0;
    end else begin
      iss_v_q    <= iss_v_d;
      iss_pc_q   <= iss_pc_d;
      iss_addr_q <= iss_addr_d;
      iss_data_q <= iss_data_d;
      iss_mode_q <= iss_mode_d;
      inc_q      <= pc_inc;
      if (Write_Reg || Write_PC) wr_count_q <= wr_count_q + 16'd1;
    end
  end

  // Write strobes and data; strobes are masked during reset so a pending
  // issue never reaches the register file.
  always_comb begin
    mode_ok   = mode_legal(iss_mode_q);
    pc_wr_exp = iss_v_q & iss_pc_q & mode_ok;
    Write_Reg = iss_v_q & ~iss_pc_q & mode_ok & ~Rst;
    Write_PC  = (pc_wr_exp | inc_q) & ~Rst;
    mode_err  = iss_v_q & ~mode_ok & ~Rst;
    PC_New    = (inc_q && !pc_wr_exp) ? (R_Data_PC + PC_STEP_W) : iss_data_q;
    M         = iss_v_q ? iss_mode_q : core_mode;
    W_Addr    = iss_addr_q;
    W_Data    = iss_data_q;
    wr_count  = wr_count_q;
  end

endmodule

// File: tb/tb_regfile_sched.sv
module tb_regfile_sched;

  logic        clk = 1'b0;
  logic        Rst;
  logic [4:0]  core_mode;
  logic        wb_valid, wb_pc;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  wb_mode;
  logic        wb_ready;
  logic        dbg_valid, dbg_pc, dbg_lock;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [4:0]  dbg_mode;
  logic        dbg_ready;
  logic        pc_inc;
  logic [31:0] R_Data_PC;
  logic [4:0]  M;
  logic [3:0]  W_Addr;
  logic [31:0] W_Data;
  logic        Write_Reg, Write_PC;
  logic [31:0] PC_New;
  logic        mode_err;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  regfile_sched #(.STARVE_MAX(4), .PC_STEP(4)) dut (
    .clk(clk), .Rst(Rst), .core_mode(core_mode),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_mode(wb_mode), .wb_ready(wb_ready),
    .dbg_valid(dbg_valid), .dbg_pc(dbg_pc), .dbg_lock(dbg_lock),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_mode(dbg_mode),
    .dbg_ready(dbg_ready), .pc_inc(pc_inc), .R_Data_PC(R_Data_PC),
    .M(M), .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .Write_PC(Write_PC), .PC_New(PC_New), .mode_err(mode_err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; core_mode = 5'b10011;
    wb_valid = 0; wb_pc = 0; wb_addr = 0; wb_data = 0; wb_mode = 0;
    dbg_valid = 0; dbg_pc = 0; dbg_lock = 0; dbg_addr = 0; dbg_data = 0; dbg_mode = 0;
    pc_inc = 0; R_Data_PC = 32'h0000_1000;
    step(); step();
    Rst = 1'b0;
    #1;
    checks++; if (Write_Reg !== 1'b0) begin errors++; $display("FAIL rst_write_reg got %b want 0", Write_Reg); end
    checks++; if (Write_PC !== 1'b0) begin errors++; $display("FAIL rst_write_pc got %b want 0", Write_PC); end
    checks++; if (mode_err !== 1'b0) begin errors++; $display("FAIL rst_mode_err got %b want 0", mode_err); end
    checks++; if (W_Addr !== 4'd0) begin errors++; $display("FAIL rst_w_addr got %h want 0", W_Addr); end
    checks++; if (W_Data !== 32'd0) begin errors++; $display("FAIL rst_w_data got %h want 0", W_Data); end
    checks++; if (PC_New !== 32'd0) begin errors++; $display("FAIL rst_pc_new got %h want 0", PC_New); end
    checks++; if (M !== 5'b10011) begin errors++; $display("FAIL rst_m got %b want 10011", M); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL rst_wr_count got %0d want 0", wr_count); end
  endtask

  task automatic test_single_write();
    core_mode = 5'b10000;
    wb_valid = 1; wb_pc = 0; wb_addr = 4'd3; wb_data = 32'h1234_5678; wb_mode = 5'b10011;
    #1;
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL single_wb_ready got %b want 1", wb_ready); end
    step();
    wb_valid = 0;
    #1;
    checks++; if (Write_Reg !== 1'b1) begin errors++; $display("FAIL single_write_reg got %b want 1", Write_Reg); end
    checks++; if (Write_PC !== 1'b0) begin errors++; $display("FAIL single_write_pc got %b want 0", Write_PC); end
    checks++; if (W_Addr !== 4'd3) begin errors++; $display("FAIL single_w_addr got %0d want 3", W_Addr); end
    checks++; if (W_Data !== 32'h1234_5678) begin errors++; $display("FAIL single_w_data got %h want 12345678", W_Data); end
    checks++; if (M !== 5'b10011) begin errors++; $display("FAIL single_m got %b want 10011", M); end
    step();
    #1;
    checks++; if (Write_Reg !== 1'b0) begin errors++; $display("FAIL single_one_cycle got %b want 0", Write_Reg); end
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL single_wr_count got %0d want 1", wr_count); end
    checks++; if (M !== 5'b10000) begin errors++; $display("FAIL single_m_idle got %b want 10000", M); end
  endtask

  task automatic test_starvation();
    logic exp_d;
    wb_valid = 1; wb_pc = 0; wb_mode = 5'b10011;
    dbg_valid = 1; dbg_pc = 0; dbg_lock = 0; dbg_mode = 5'b10000;
    for (int i = 0; i < 10; i++) begin
      wb_addr = 4'(i); wb_data = 32'(i); dbg_addr = 4'(i); dbg_data = 32'(100 + i);
      #1;
      exp_d = (i == 4) || (i == 9);
      checks++; if (wb_ready !== !exp_d) begin errors++; $display("FAIL starve_wb_ready cyc %0d got %b want %b", i, wb_ready, !exp_d); end
      checks++; if (dbg_ready !== exp_d) begin errors++; $display("FAIL starve_dbg_ready cyc %0d got %b want %b", i, dbg_ready, exp_d); end
      step();
    end
    wb_valid = 0; dbg_valid = 0;
    step();
    #1;
    checks++; if (wr_count !== 16'd11) begin errors++; $display("FAIL starve_wr_count got %0d want 11", wr_count); end
  endtask

  task automatic test_debug_lock();
    logic [7:0] exp_wb  = 8'b1000_1111;
    logic [7:0] exp_dbg = 8'b0111_0000;
    wb_valid = 1; wb_pc = 0; wb_mode = 5'b10011; wb_addr = 4'd1; wb_data = 32'hC0DE_0000;
    dbg_pc = 0; dbg_mode = 5'b11111; dbg_addr = 4'd9;
    for (int i = 0; i < 8; i++) begin
      dbg_valid = (i < 7);
      dbg_lock  = (i < 6);
      dbg_data  = 32'hD000_0000 + 32'(i);
      #1;
      checks++; if (wb_ready !== exp_wb[i]) begin errors++; $display("FAIL lock_wb_ready cyc %0d got %b want %b", i, wb_ready, exp_wb[i]); end
      checks++; if (dbg_ready !== exp_dbg[i]) begin errors++; $display("FAIL lock_dbg_ready cyc %0d got %b want %b", i, dbg_ready, exp_dbg[i]); end
      if (i == 5) begin
        checks++; if (W_Data !== 32'hD000_0004) begin errors++; $display("FAIL lock_beat1_data got %h want d0000004", W_Data); end
      end
      if (i == 7) begin
        checks++; if (W_Data !== 32'hD000_0006 || Write_Reg !== 1'b1) begin errors++; $display("FAIL lock_beat3 data %h wr %b want d0000006 1", W_Data, Write_Reg); end
      end
      step();
    end
    wb_valid = 0; dbg_valid = 0; dbg_lock = 0;
    step();
    #1;
    checks++; if (wr_count !== 16'd19) begin errors++; $display("FAIL lock_wr_count got %0d want 19", wr_count); end
  endtask

  task automatic test_pc_step();
    R_Data_PC = 32'hFFFF_FFFC;
    pc_inc = 1;
    step();
    pc_inc = 0;
    #1;
    checks++; if (Write_PC !== 1'b1) begin errors++; $display("FAIL step_write_pc got %b want 1", Write_PC); end
    checks++; if (PC_New !== 32'd0) begin errors++; $display("FAIL step_pc_new got %h want 0", PC_New); end
    checks++; if (Write_Reg !== 1'b0) begin errors++; $display("FAIL step_write_reg got %b want 0", Write_Reg); end
    step();
    #1;
    checks++; if (Write_PC !== 1'b0 || wr_count !== 16'd20) begin errors++; $display("FAIL step_after wpc %b cnt %0d want 0 20", Write_PC, wr_count); end
    pc_inc = 1; wb_valid = 1; wb_pc = 1; wb_data = 32'h0000_0100; wb_mode = 5'b10011;
    #1;
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL ovr_wb_ready got %b want 1", wb_ready); end
    step();
    pc_inc = 0; wb_valid = 0; wb_pc = 0;
    #1;
    checks++; if (Write_PC !== 1'b1 || PC_New !== 32'h100) begin errors++; $display("FAIL ovr_pc wpc %b pc %h want 1 00000100", Write_PC, PC_New); end
    checks++; if (Write_Reg !== 1'b0) begin errors++; $display("FAIL ovr_write_reg got %b want 0", Write_Reg); end
    step();
    #1;
    checks++; if (Write_PC !== 1'b0) begin errors++; $display("FAIL ovr_single_write got %b want 0", Write_PC); end
    checks++; if (wr_count !== 16'd21) begin errors++; $display("FAIL ovr_wr_count got %0d want 21", wr_count); end
  endtask

  task automatic test_illegal_mode();
    dbg_valid = 1; dbg_lock = 0; dbg_pc = 0; dbg_mode = 5'b10100; dbg_addr = 4'd5; dbg_data = 32'hBAD0_0005;
    #1;
    checks++; if (dbg_ready !== 1'b1) begin errors++; $display("FAIL ill_dbg_ready got %b want 1", dbg_ready); end
    step();
    dbg_valid = 0;
    #1;
    checks++; if (mode_err !== 1'b1) begin errors++; $display("FAIL ill_mode_err got %b want 1", mode_err); end
    checks++; if (Write_Reg !== 1'b0 || Write_PC !== 1'b0) begin errors++; $display("FAIL ill_strobes wr %b wpc %b want 0 0", Write_Reg, Write_PC); end
    step();
    #1;
    checks++; if (mode_err !== 1'b0) begin errors++; $display("FAIL ill_mode_err_pulse got %b want 0", mode_err); end
    checks++; if (wr_count !== 16'd21) begin errors++; $display("FAIL ill_wr_count got %0d want 21", wr_count); end
  endtask

  task automatic test_reset_mid_lock();
    dbg_valid = 1; dbg_lock = 1; dbg_pc = 0; dbg_mode = 5'b10011; dbg_addr = 4'd7; dbg_data = 32'h7777_7777;
    wb_valid = 0;
    #1;
    checks++; if (dbg_ready !== 1'b1) begin errors++; $display("FAIL rml_dbg_ready got %b want 1", dbg_ready); end
    step();
    dbg_valid = 0; wb_valid = 1; wb_pc = 0; wb_mode = 5'b10011;
    #1;
    checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL rml_locked_wb_ready got %b want 0", wb_ready); end
    Rst = 1;
    #1;
    checks++; if (Write_Reg !== 1'b0 || mode_err !== 1'b0) begin errors++; $display("FAIL rml_discard wr %b err %b want 0 0", Write_Reg, mode_err); end
    step();
    Rst = 0;
    #1;
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL rml_open_wb_ready got %b want 1", wb_ready); end
    checks++; if (Write_Reg !== 1'b0 || Write_PC !== 1'b0) begin errors++; $display("FAIL rml_strobes wr %b wpc %b want 0 0", Write_Reg, Write_PC); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL rml_wr_count got %0d want 0", wr_count); end
    wb_valid = 0;
    #1;
    checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL rml_wb_ready_idle got %b want 0", wb_ready); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_starvation();
    test_debug_lock();
    test_pc_step();
    test_illegal_mode();
    test_reset_mid_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
